// File: rtl/josh_pkg.sv
// Shared constants and FSM encoding for the collision map.
package josh_pkg;
    localparam logic [7:0] SCREEN_W  = 8'd160;
    localparam logic [6:0] SCREEN_H  = 7'd120;
    localparam logic [6:0] LAST_ROW  = SCREEN_H - 7'd1;
    localparam int unsigned BOX      = 4;
    localparam logic [2:0] COLOUR_BG = 3'b000;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/row_store.sv
// Occupancy array: one bit write port, one registered row read, row clear.
module row_store
    import josh_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [7:0]          wr_x,
    input  logic [6:0]          wr_y,
    input  logic                wr_bit,
    input  logic                clr_en,
    input  logic [6:0]          clr_row,
    input  logic [7:0]          rd_row,
    output logic [SCREEN_W-1:0] rd_data
);
    logic [SCREEN_W-1:0] mem [SCREEN_H];

    // Read sees the old row contents when a write lands on it this edge.
    always_ff @(posedge clk) begin
        if (rd_row < {1'b0, SCREEN_H})
            rd_data <= mem[rd_row[6:0]];
        else
            rd_data <= '0;
        if (clr_en)
            mem[clr_row] <= '0;
        else if (wr_en)
            mem[wr_y][wr_x] <= wr_bit;
    end
endmodule

// File: rtl/collision_map.sv
// Pixel occupancy map with 4x4 box collision queries and a row-by-row clear.
module collision_map
    import josh_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       plot,
    input  logic [7:0] plot_x,
    input  logic [6:0] plot_y,
    input  logic [2:0] plot_colour,
    input  logic       clear,
    output logic       busy,
    input  logic       qry_valid,
    input  logic [7:0] qry_x,
    input  logic [6:0] qry_y,
    output logic       qry_ready,
    output logic       hit_valid,
    output logic       hit
);
    state_t              state;
    logic [6:0]          row_cnt;
    logic [7:0]          bx;
    logic [6:0]          by;
    logic [1:0]          step;
    logic                acc;
    logic                rd_pend;
    logic [7:0]          rd_row;
    logic [SCREEN_W-1:0] rd_data;
    logic [SCREEN_W-1:0] shifted;
    logic                box_hit;
    logic                wr_en;

    assign busy      = (state == ST_CLEAR);
    assign qry_ready = (state == ST_IDLE) && !clear;
    assign rd_row    = {1'b0, by} + {6'b0, step};
    assign wr_en     = plot && (plot_x < SCREEN_W) && (plot_y < SCREEN_H)
                       && (state != ST_CLEAR);

    // Columns past the right edge shift in as zeros, so no wrap-around.
    assign shifted = rd_data >> bx;
    assign box_hit = |shifted[BOX-1:0];

    row_store u_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_x    (plot_x),
        .wr_y    (plot_y),
        .wr_bit  (plot_colour != COLOUR_BG),
        .clr_en  (state == ST_CLEAR),
        .clr_row (row_cnt),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_CLEAR;
            row_cnt   <= '0;
            bx        <= '0;
            by        <= '0;
            step      <= '0;
            acc       <= 1'b0;
            rd_pend   <= 1'b0;
            hit_valid <= 1'b0;
            hit       <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            hit       <= 1'b0;
            rd_pend   <= (state == ST_SCAN);
            unique case (state)
                ST_CLEAR: begin
                    if (row_cnt == LAST_ROW) begin
                        state   <= ST_IDLE;
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + 7'd1;
                    end
                end
                ST_IDLE: begin
                    if (clear) begin
                        state   <= ST_CLEAR;
                        row_cnt <= '0;
                    end else if (qry_valid) begin
                        state <= ST_SCAN;
                        bx    <= qry_x;
                        by    <= qry_y;
                        step  <= '0;
                        acc   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    // Row data lags its address by one cycle.
                    if (rd_pend)
                        acc <= acc | box_hit;
                    step <= step + 2'd1;
                    if (step == 2'd3)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    hit_valid <= 1'b1;
                    hit       <= acc | box_hit;
                    state     <= ST_IDLE;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_map.sv
// Randomised bench for collision_map against a pixel-array reference.
module tb_collision_map;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       plot = 1'b0;
    logic [7:0] plot_x = '0;
    logic [6:0] plot_y = '0;
    logic [2:0] plot_colour = '0;
    logic       clear = 1'b0;
    logic       busy;
    logic       qry_valid = 1'b0;
    logic [7:0] qry_x = '0;
    logic [6:0] qry_y = '0;
    logic       qry_ready;
    logic       hit_valid;
    logic       hit;

    bit occ [120][160];
    int n_vec = 0;
    int n_bad = 0;

    collision_map dut (
        .clk         (clk),
        .resetn      (resetn),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .clear       (clear),
        .busy        (busy),
        .qry_valid   (qry_valid),
        .qry_x       (qry_x),
        .qry_y       (qry_y),
        .qry_ready   (qry_ready),
        .hit_valid   (hit_valid),
        .hit         (hit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input int x, input int y);
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 4; dx++)
                if (y + dy < 120 && x + dx < 160 && occ[y+dy][x+dx])
                    return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 120; r++)
            for (int c = 0; c < 160; c++)
                occ[r][c] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            n++;
            tick();
        end
        check(tag, n, 120);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!qry_ready && n < 300) begin
            n++;
            tick();
        end
        check(tag, qry_ready, 1);
    endtask

    task automatic do_plot(input int x, input int y, input logic [2:0] c);
        plot_x      = x[7:0];
        plot_y      = y[6:0];
        plot_colour = c;
        plot        = 1'b1;
        tick();
        plot = 1'b0;
        if (x < 160 && y < 120)
            occ[y][x] = (c != 3'b000);
    endtask

    task automatic do_query(input string tag, input int x, input int y);
        int  k = 0;
        bit  exp_hit;
        exp_hit = model_hit(x, y);
        wait_ready({tag, "_rdy"});
        qry_x     = x[7:0];
        qry_y     = y[6:0];
        qry_valid = 1'b1;
        tick();
        qry_valid = 1'b0;
        while (!hit_valid && k < 20) begin
            k++;
            tick();
        end
        check({tag, "_lat"}, k, 5);
        check({tag, "_hit"}, hit, exp_hit);
        tick();
        check({tag, "_pulse"}, {hit_valid, hit}, 0);
    endtask

    initial begin
        int np, x, y;
        logic [2:0] c;

        model_clear();
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_ready", qry_ready, 0);
        check("rst_hv", hit_valid, 0);
        check("rst_hit", hit, 0);
        resetn = 1'b1;
        count_busy("rst_sweep");
        do_query("q00", 0, 0);

        do_plot(10, 20, 3'b100);
        do_query("q_8_18", 8, 18);
        do_query("q_11_20", 11, 20);

        do_plot(159, 119, 3'b101);
        do_query("q_corner_a", 157, 117);
        do_query("q_corner_b", 158, 118);

        do_plot(30, 30, 3'b001);
        do_query("q_30_set", 30, 30);
        do_plot(30, 30, 3'b000);
        do_query("q_30_bg", 30, 30);
        do_plot(200, 5, 3'b111);
        do_query("q_oor", 157, 2);

        for (int it = 0; it < 60; it++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
                x = $urandom_range(0, 47);
                y = $urandom_range(0, 35);
                if ($urandom_range(0, 7) == 0)
                    x = $urandom_range(150, 210);
                c = 3'($urandom_range(0, 7));
                do_plot(x, y, c);
            end
            do_query("q_rand", $urandom_range(0, 47), $urandom_range(0, 37));
        end

        wait_ready("clr_rdy");
        clear     = 1'b1;
        qry_x     = 8'd8;
        qry_y     = 7'd18;
        qry_valid = 1'b1;
        #1;
        check("clr_qready", qry_ready, 0);
        tick();
        clear     = 1'b0;
        qry_valid = 1'b0;
        check("clr_busy", busy, 1);
        count_busy("clr_sweep");
        model_clear();
        do_query("q_after_clr", 8, 18);
        do_plot(0, 0, 3'b011);
        do_query("q_nowrap", 158, 118);
        do_query("q_origin", 0, 0);

        do_plot(50, 50, 3'b010);
        wait_ready("mid_rdy");
        qry_x     = 8'd49;
        qry_y     = 7'd49;
        qry_valid = 1'b1;
        tick();
        qry_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_rst_hv", hit_valid, 0);
        end
        resetn = 1'b1;
        count_busy("mid_rst_sweep");
        model_clear();
        do_query("q_after_rst", 49, 49);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/collision_map.md
COLLISION_MAP -- requirements
Module: collision_map

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port resetn, input, 1: asynchronous active-low reset.
REQ-004 Port plot, input, 1: pixel write strobe from the screen-drawing logic.
REQ-005 Port plot_x, input, 8: pixel column, 0..159.
REQ-006 Port plot_y, input, 7: pixel row, 0..119.
REQ-007 Port plot_colour, input, 3: pixel colour; 3'b000 is background (empty).
REQ-008 Port clear, input, 1: request to erase the whole map.
REQ-009 Port busy, output, 1: high while a clear sweep is in progress.
REQ-010 Port qry_valid, input, 1: collision query request.
REQ-011 Port qry_x, input, 8: query box left column.
REQ-012 Port qry_y, input, 7: query box top row.
REQ-013 Port qry_ready, output, 1: query can be accepted this cycle.
REQ-014 Port hit_valid, output, 1: one-cycle pulse marking a query result.
REQ-015 Port hit, output, 1: query result, valid only with hit_valid.

Function
REQ-016 Occupancy SHALL be stored as 120 rows of 160 bits; a bit is 1 when the last accepted plot to that pixel had a non-zero colour.
REQ-017 A plot with plot=1, plot_x<160 and plot_y<120, in any state other than CLEAR, SHALL update the bit at the next clock edge; out-of-range plots SHALL be ignored.
REQ-018 The FSM SHALL have states CLEAR, IDLE, SCAN and DONE.
REQ-019 CLEAR: zero one row per cycle, rows 0..119 (120 cycles); busy=1; plots ignored; then go to IDLE.
REQ-020 IDLE: clear=1 goes to CLEAR with the row counter at 0; otherwise qry_valid and qry_ready go to SCAN, capturing qry_x and qry_y.
REQ-021 qry_ready SHALL be 1 only in IDLE with clear=0; clear wins over a simultaneous query.
REQ-022 SCAN SHALL last exactly 4 cycles, reading rows qry_y..qry_y+3, and OR the columns qry_x..qry_x+3 of each row into a hit accumulator cleared on accept.
REQ-023 Rows >=120 and columns >=160 inside the box SHALL contribute 0; there is no wrap-around.
REQ-024 DONE SHALL assert hit_valid=1 and hit=accumulator for exactly one cycle, then return to IDLE.
REQ-025 Latency: a query accepted at edge N SHALL produce hit_valid high in the cycle after edge N+5.
REQ-026 A plot to the row being read in the same cycle SHALL NOT be seen by that read (read-before-write); it is seen by later reads.
REQ-027 clear asserted outside IDLE SHALL be ignored; it is not queued.
REQ-028 hit SHALL be 0 whenever hit_valid=0.

Reset
REQ-029 When resetn is asserted, the state SHALL go to CLEAR with the row counter at 0. Outputs SHALL be: busy=1, qry_ready=0, hit_valid=0, hit=0.
REQ-030 Reset asserted mid-query SHALL abort the query with no hit_valid pulse; a full 120-cycle clear SHALL follow deassertion.
REQ-031 The occupancy array SHALL NOT be reset directly; it is initialised only by the CLEAR sweep.

Structure
REQ-032 The shared package josh_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, BOX=4, COLOUR_BG=3'b000 and the FSM state encoding.
REQ-033 The array SHALL be in sub-module row_store: one synchronous write port, one row-read port, and a row-clear input.

Verification
REQ-034 Reset release, then idle -> busy=1 for exactly 120 cycles, then qry_ready=1; a query at (0,0) returns hit=0.
REQ-035 Plot (10,20) colour 3'b100, then query (8,18) -> hit_valid 5 cycles after accept with hit=1; query (11,20) -> hit=0.
REQ-036 Plot (159,119) non-zero, query (157,117) -> hit=1; query (158,118) -> hit=1 with no wrap, and plot (0,0) does not make it hit.
REQ-037 Plot (30,30) colour 0 over an existing 1, then query (30,30) -> hit=0; plot (200,5) -> no change.
REQ-038 clear and qry_valid in the same IDLE cycle -> qry_ready=0 and busy=1 next cycle, with 120 cycles of busy; the query is accepted afterward and returns hit=0.
REQ-039 resetn pulsed during SCAN -> no hit_valid pulse, a full clear sweep follows, and earlier plots return hit=0.
